// File: rtl/regfile_fwd_hz.sv
`default_nettype none
// ============================================================================
// Module   : regfile_fwd_hz
// Purpose  : ID-stage integer register file with HI/LO storage, EX/MEM/WB
//            result bypass, a registered HI/LO-busy scoreboard for multicycle
//            mult/div, and a single stall request for load-use and HI/LO-busy
//            hazards.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DW      data width of GPRs and HI/LO
//   AW      register address width (2**AW entries, entry 0 reads as zero)
//   NUM_RD  number of combinational GPR read ports
// Ports
//   clk, resetn                          clock, async active-low reset
//   rd_en / raddr / rdata                GPR read ports (port i packed at
//                                        [i*AW +: AW] / [i*DW +: DW])
//   we / waddr / wdata                   WB commit write
//   ex_*  / mem_*                        EX / MEM stage GPR results
//   hi_we / lo_we / hi_wdata / lo_wdata  WB commit to HI / LO
//   ex_hi_we .. mem_lo                   EX / MEM stage HI/LO results
//   hilo_busy_set / hilo_busy_clr        multicycle op started / finished
//   hi_rd_en / lo_rd_en                  ID instruction reads HI / LO
//   hi_rdata / lo_rdata                  HI / LO read data
//   hilo_busy                            registered scoreboard flag
//   stall_req                            hold IF/ID, bubble into EX
// Configuration macro
//   RF_BYPASS_EN  defined   : full EX/MEM/WB bypass, stall only on load-use
//                             and HI/LO busy.
//                 undefined : only the same-cycle WB write is bypassed; any
//                             in-flight EX/MEM producer stalls the reader.
// ============================================================================
module regfile_fwd_hz #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2
) (
    input  logic                 clk,
    input  logic                 resetn,

    input  logic [NUM_RD-1:0]    rd_en,
    input  logic [NUM_RD*AW-1:0] raddr,
    output logic [NUM_RD*DW-1:0] rdata,

    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [DW-1:0]        wdata,

    input  logic                 ex_we,
    input  logic [AW-1:0]        ex_waddr,
    input  logic [DW-1:0]        ex_wdata,
    input  logic                 ex_is_load,

    input  logic                 mem_we,
    input  logic [AW-1:0]        mem_waddr,
    input  logic [DW-1:0]        mem_wdata,
    input  logic                 mem_is_load,

    input  logic                 hi_we,
    input  logic                 lo_we,
    input  logic [DW-1:0]        hi_wdata,
    input  logic [DW-1:0]        lo_wdata,

    input  logic                 ex_hi_we,
    input  logic                 ex_lo_we,
    input  logic [DW-1:0]        ex_hi,
    input  logic [DW-1:0]        ex_lo,

    input  logic                 mem_hi_we,
    input  logic                 mem_lo_we,
    input  logic [DW-1:0]        mem_hi,
    input  logic [DW-1:0]        mem_lo,

    input  logic                 hilo_busy_set,
    input  logic                 hilo_busy_clr,

    input  logic                 hi_rd_en,
    input  logic                 lo_rd_en,
    output logic [DW-1:0]        hi_rdata,
    output logic [DW-1:0]        lo_rdata,

    output logic                 hilo_busy,
    output logic                 stall_req
);

    localparam int C_DEPTH = 2 ** AW;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DW-1:0] gpr_q [0:C_DEPTH-1];
    logic [DW-1:0] gpr_d [0:C_DEPTH-1];
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;
    logic          busy_q, busy_d;

    // Next-state: entry 0 is never written so it stays at its reset value.
    always_comb begin
        for (int k = 0; k < C_DEPTH; k++) begin
            gpr_d[k] = gpr_q[k];
        end
        if (we && (waddr != '0)) begin
            gpr_d[waddr] = wdata;
        end
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (hi_we) hi_d = hi_wdata;
        if (lo_we) lo_d = lo_wdata;
    end

    // Set has priority over clear so a new op issued in the same cycle the
    // previous one finishes keeps the scoreboard busy.
    always_comb begin
        busy_d = busy_q;
        if (hilo_busy_set) begin
            busy_d = 1'b1;
        end else if (hilo_busy_clr) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < C_DEPTH; k++) begin
                gpr_q[k] <= '0;
            end
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            for (int k = 0; k < C_DEPTH; k++) begin
                gpr_q[k] <= gpr_d[k];
            end
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= busy_d;
        end
    end

    // ------------------------------------------------------------------------
    // GPR read ports and per-port load-use hazard
    // ------------------------------------------------------------------------
    logic [NUM_RD-1:0] w_hazard;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_port
        logic [AW-1:0] w_addr;
        logic          w_addr_nz;
        logic          w_ex_hit;
        logic          w_mem_hit;
        logic          w_wb_hit;
        logic [DW-1:0] w_data;

        assign w_addr    = raddr[gi*AW +: AW];
        assign w_addr_nz = (w_addr != '0);

        // A producer targeting r0 must never match, even when the reader
        // also addresses r0.
        assign w_ex_hit  = ex_we  && (ex_waddr  != '0) && (ex_waddr  == w_addr);
        assign w_mem_hit = mem_we && (mem_waddr != '0) && (mem_waddr == w_addr);
        assign w_wb_hit  = we     && (waddr     != '0) && (waddr     == w_addr);

        always_comb begin
            w_data = gpr_q[w_addr];
`ifdef RF_BYPASS_EN
            if (!w_addr_nz) begin
                w_data = '0;
            end else if (w_ex_hit) begin
                w_data = ex_wdata;
            end else if (w_mem_hit) begin
                w_data = mem_wdata;
            end else if (w_wb_hit) begin
                w_data = wdata;
            end
`else
            if (!w_addr_nz) begin
                w_data = '0;
            end else if (w_wb_hit) begin
                w_data = wdata;
            end
`endif
        end

        // Reset forces the outputs to zero even though the WB bypass path
        // would otherwise pass live inputs straight through.
        assign rdata[gi*DW +: DW] = resetn ? w_data : '0;

`ifdef RF_BYPASS_EN
        // Youngest producer decides: a non-load EX hit masks an older MEM load.
        assign w_hazard[gi] = rd_en[gi] && w_addr_nz &&
                              (w_ex_hit ? ex_is_load : (w_mem_hit && mem_is_load));
`else
        assign w_hazard[gi] = rd_en[gi] && w_addr_nz && (w_ex_hit || w_mem_hit);
`endif
    end

    // ------------------------------------------------------------------------
    // HI/LO read and HI/LO hazard
    // ------------------------------------------------------------------------
    logic [DW-1:0] w_hi;
    logic [DW-1:0] w_lo;
    logic          w_hilo_stall;
    logic          w_hilo_rd;

    assign w_hilo_rd = hi_rd_en | lo_rd_en;

`ifdef RF_BYPASS_EN
    always_comb begin
        if (ex_hi_we) begin
            w_hi = ex_hi;
        end else if (mem_hi_we) begin
            w_hi = mem_hi;
        end else if (hi_we) begin
            w_hi = hi_wdata;
        end else begin
            w_hi = hi_q;
        end
    end

    always_comb begin
        if (ex_lo_we) begin
            w_lo = ex_lo;
        end else if (mem_lo_we) begin
            w_lo = mem_lo;
        end else if (lo_we) begin
            w_lo = lo_wdata;
        end else begin
            w_lo = lo_q;
        end
    end

    // The registered flag is used on purpose: the clear cycle still stalls and
    // the result is picked up next cycle through the bypass.
    assign w_hilo_stall = w_hilo_rd && busy_q;
`else
    assign w_hi = hi_we ? hi_wdata : hi_q;
    assign w_lo = lo_we ? lo_wdata : lo_q;

    assign w_hilo_stall = w_hilo_rd &&
                          (ex_hi_we || ex_lo_we || mem_hi_we || mem_lo_we || busy_q);

    // Bypass-only inputs have no consumer in this build.
    logic w_unused_nobypass;
    assign w_unused_nobypass = ^{ex_wdata, mem_wdata, ex_is_load, mem_is_load,
                                 ex_hi, ex_lo, mem_hi, mem_lo};
`endif

    assign hi_rdata  = resetn ? w_hi : '0;
    assign lo_rdata  = resetn ? w_lo : '0;
    assign hilo_busy = busy_q;
    assign stall_req = resetn && ((|w_hazard) || w_hilo_stall);

endmodule
`default_nettype wire
